// File: rtl/axi_slave_pkg.sv
// ---------------------------------------------------------------------------
// axi_slave_pkg
// Shared definitions for the AXI4 memory subordinate:
//   - response codes (RESP_OKAY, RESP_SLVERR)
//   - burst type codes (BURST_FIXED, BURST_INCR, BURST_WRAP)
//   - write / read FSM state enums
//   - burst legality helpers
// Optional build macro: AXI_SLAVE_WRAP_EN (accept WRAP bursts of 2/4/8/16 beats).
// ---------------------------------------------------------------------------
package axi_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

  // Whole-burst rejection: beat wider than the bus, or a burst type this
  // build does not implement.
  function automatic logic burst_unsupported(input logic [1:0] burst,
                                             input logic [2:0] size,
                                             input logic [2:0] max_size);
    logic err;
    err = (size > max_size);
`ifdef AXI_SLAVE_WRAP_EN
    if (burst != BURST_INCR && burst != BURST_WRAP) err = 1'b1;
`else
    if (burst != BURST_INCR) err = 1'b1;
`endif
    return err;
  endfunction

`ifdef AXI_SLAVE_WRAP_EN
  // WRAP bursts must be 2, 4, 8 or 16 beats (len = beats - 1).
  function automatic logic wrap_len_bad(input logic [7:0] len);
    return !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
  endfunction
`endif

endpackage

// File: rtl/axi_addr_gen.sv
// ---------------------------------------------------------------------------
// axi_addr_gen
// Combinational next-beat address for one AXI channel.
//   addr      in  ADDR_W  current beat address
//   size      in  3       log2 bytes per beat
//   len       in  8       beats minus 1 (used for WRAP boundary)
//   burst     in  2       burst type
//   next_addr out ADDR_W  address of the following beat
// INCR: the current address is aligned down to the beat size before the
// step is added, so an unaligned start lands on aligned addresses afterwards.
// Arithmetic wraps modulo 2^ADDR_W.
// Optional build macro: AXI_SLAVE_WRAP_EN (WRAP bursts fold back to the
// boundary of a (len+1)<<size byte window).
// ---------------------------------------------------------------------------
module axi_addr_gen
  import axi_slave_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] aligned;
  logic [ADDR_W-1:0] incr_addr;

  always_comb begin
    step      = ADDR_W'(1) << size;
    aligned   = addr & ~(step - ADDR_W'(1));
    incr_addr = aligned + step;
  end

`ifdef AXI_SLAVE_WRAP_EN
  logic [ADDR_W-1:0] wrap_mask;

  // Window size is a power of two for every legal WRAP length, so the
  // boundary is just the address with the in-window bits cleared.
  always_comb begin
    wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    if (burst == BURST_WRAP)
      next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
    else
      next_addr = incr_addr;
  end
`else
  logic unused_wrap_inputs;
  assign unused_wrap_inputs = ^{len, burst};
  assign next_addr = incr_addr;
`endif

endmodule

// File: rtl/axi_slave_mem.sv
// ---------------------------------------------------------------------------
// axi_slave_mem
// AXI4 subordinate backed by a word-addressed memory at base address 0.
// Independent write (AW/W/B) and read (AR/R) FSMs run concurrently.
// Ports:
//   aclk, areset (async, active-low)
//   AW: awaddr, awlen, awsize, awburst, awvalid / awready
//   W : wdata, wstrb, wlast, wvalid / wready
//   B : bresp, bvalid / bready
//   AR: araddr, arlen, arsize, arburst, arvalid / arready
//   R : rdata, rresp, rlast, rvalid / rready
// Errors (SLVERR): beat outside MEM_DEPTH (write dropped, read returns 0),
// size wider than the bus, unsupported burst type, wlast misplacement.
// Optional build macro: AXI_SLAVE_WRAP_EN (WRAP bursts of 2/4/8/16 beats).
// ---------------------------------------------------------------------------
module axi_slave_mem
  import axi_slave_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 64
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);

  localparam int         STRB_W     = DATA_W / 8;
  localparam int         BYTE_SHIFT = $clog2(STRB_W);
  localparam int         IDX_W      = $clog2(MEM_DEPTH);
  localparam logic [2:0] MAX_SIZE   = 3'(BYTE_SHIFT);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // ---------------- burst legality on the request channels ----------------
  logic aw_burst_err;
  logic ar_burst_err;

  always_comb begin
    aw_burst_err = burst_unsupported(awburst, awsize, MAX_SIZE);
    ar_burst_err = burst_unsupported(arburst, arsize, MAX_SIZE);
`ifdef AXI_SLAVE_WRAP_EN
    if (awburst == BURST_WRAP && wrap_len_bad(awlen)) aw_burst_err = 1'b1;
    if (arburst == BURST_WRAP && wrap_len_bad(arlen)) ar_burst_err = 1'b1;
`endif
  end

  // ---------------- write channel ----------------
  wr_state_t         wr_state;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [ADDR_W-1:0] wr_addr_next;
  logic [7:0]        wr_len_reg;
  logic [7:0]        wr_cnt_reg;
  logic [2:0]        wr_size_reg;
  logic [1:0]        wr_burst_reg;
  logic              wr_burst_err_reg;
  logic              wr_err_reg;
  logic [ADDR_W-1:0] wr_idx;
  logic              wr_in_range;
  logic              wr_last_beat;
  logic              wr_beat_err;
  logic              wr_mem_en;

  axi_addr_gen #(.ADDR_W(ADDR_W)) u_wr_addr_gen (
    .addr      (wr_addr_reg),
    .size      (wr_size_reg),
    .len       (wr_len_reg),
    .burst     (wr_burst_reg),
    .next_addr (wr_addr_next)
  );

  assign wr_idx       = wr_addr_reg >> BYTE_SHIFT;
  assign wr_in_range  = wr_idx < ADDR_W'(MEM_DEPTH);
  assign wr_last_beat = (wr_cnt_reg == wr_len_reg);
  // wlast must appear exactly on the final beat
  assign wr_beat_err  = !wr_in_range || (wlast != wr_last_beat);
  // Rejected bursts never touch memory, only in-range beats of legal ones do
  assign wr_mem_en    = (wr_state == W_DATA) && wvalid && wready &&
                        wr_in_range && !wr_burst_err_reg;

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      wr_state         <= W_IDLE;
      awready          <= 1'b1;
      wready           <= 1'b0;
      bvalid           <= 1'b0;
      bresp            <= RESP_OKAY;
      wr_addr_reg      <= '0;
      wr_len_reg       <= '0;
      wr_cnt_reg       <= '0;
      wr_size_reg      <= '0;
      wr_burst_reg     <= '0;
      wr_burst_err_reg <= 1'b0;
      wr_err_reg       <= 1'b0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (awvalid && awready) begin
            wr_addr_reg      <= awaddr;
            wr_len_reg       <= awlen;
            wr_size_reg      <= awsize;
            wr_burst_reg     <= awburst;
            wr_cnt_reg       <= '0;
            wr_burst_err_reg <= aw_burst_err;
            wr_err_reg       <= aw_burst_err;
            awready          <= 1'b0;
            wready           <= 1'b1;
            wr_state         <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid && wready) begin
            wr_addr_reg <= wr_addr_next;
            wr_cnt_reg  <= wr_cnt_reg + 8'd1;
            wr_err_reg  <= wr_err_reg || wr_beat_err;
            if (wr_last_beat) begin
              wready   <= 1'b0;
              bvalid   <= 1'b1;
              bresp    <= (wr_err_reg || wr_beat_err) ? RESP_SLVERR : RESP_OKAY;
              wr_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid   <= 1'b0;
            awready  <= 1'b1;
            wr_state <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Memory array carries no reset so it maps onto RAM; contents survive areset.
  always_ff @(posedge aclk) begin
    if (wr_mem_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[wr_idx[IDX_W-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  rd_state_t         rd_state;
  logic [ADDR_W-1:0] rd_addr_reg;   // address of the next beat to load
  logic [7:0]        rd_len_reg;
  logic [7:0]        rd_cnt_reg;    // index of the beat currently on R
  logic [2:0]        rd_size_reg;
  logic [1:0]        rd_burst_reg;
  logic              rd_burst_err_reg;
  logic [ADDR_W-1:0] rd_gen_addr;
  logic [2:0]        rd_gen_size;
  logic [7:0]        rd_gen_len;
  logic [1:0]        rd_gen_burst;
  logic              rd_gen_burst_err;
  logic [ADDR_W-1:0] rd_addr_next;
  logic [ADDR_W-1:0] rd_idx;
  logic              rd_beat_err;
  logic [DATA_W-1:0] rd_word;

  // The first beat is fetched on the AR handshake edge itself, so in IDLE
  // the beat address comes straight from the AR channel.
  always_comb begin
    if (rd_state == R_IDLE) begin
      rd_gen_addr      = araddr;
      rd_gen_size      = arsize;
      rd_gen_len       = arlen;
      rd_gen_burst     = arburst;
      rd_gen_burst_err = ar_burst_err;
    end else begin
      rd_gen_addr      = rd_addr_reg;
      rd_gen_size      = rd_size_reg;
      rd_gen_len       = rd_len_reg;
      rd_gen_burst     = rd_burst_reg;
      rd_gen_burst_err = rd_burst_err_reg;
    end
  end

  axi_addr_gen #(.ADDR_W(ADDR_W)) u_rd_addr_gen (
    .addr      (rd_gen_addr),
    .size      (rd_gen_size),
    .len       (rd_gen_len),
    .burst     (rd_gen_burst),
    .next_addr (rd_addr_next)
  );

  assign rd_idx      = rd_gen_addr >> BYTE_SHIFT;
  assign rd_beat_err = rd_gen_burst_err || !(rd_idx < ADDR_W'(MEM_DEPTH));
  assign rd_word     = rd_beat_err ? '0 : mem[rd_idx[IDX_W-1:0]];

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      rd_state         <= R_IDLE;
      arready          <= 1'b1;
      rvalid           <= 1'b0;
      rlast            <= 1'b0;
      rresp            <= RESP_OKAY;
      rdata            <= '0;
      rd_addr_reg      <= '0;
      rd_len_reg       <= '0;
      rd_cnt_reg       <= '0;
      rd_size_reg      <= '0;
      rd_burst_reg     <= '0;
      rd_burst_err_reg <= 1'b0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (arvalid && arready) begin
            rd_len_reg       <= arlen;
            rd_size_reg      <= arsize;
            rd_burst_reg     <= arburst;
            rd_burst_err_reg <= ar_burst_err;
            rd_addr_reg      <= rd_addr_next;
            rd_cnt_reg       <= '0;
            arready          <= 1'b0;
            rvalid           <= 1'b1;
            rdata            <= rd_word;
            rresp            <= rd_beat_err ? RESP_SLVERR : RESP_OKAY;
            rlast            <= (arlen == 8'd0);
            rd_state         <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid   <= 1'b0;
              rlast    <= 1'b0;
              arready  <= 1'b1;
              rd_state <= R_IDLE;
            end else begin
              // load the following beat on the same edge: no bubble
              rd_addr_reg <= rd_addr_next;
              rd_cnt_reg  <= rd_cnt_reg + 8'd1;
              rdata       <= rd_word;
              rresp       <= rd_beat_err ? RESP_SLVERR : RESP_OKAY;
              rlast       <= ((rd_cnt_reg + 8'd1) == rd_len_reg);
            end
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// ---------------------------------------------------------------------------
// tb_axi_slave_mem
// Directed self-checking bench for axi_slave_mem (ADDR_W=32, DATA_W=32,
// MEM_DEPTH=64). Inputs change on the falling edge; outputs are sampled on
// the falling edge, half a cycle away from the active rising edge.
// Expectations for the WRAP scenario follow AXI_SLAVE_WRAP_EN.
// ---------------------------------------------------------------------------
module tb_axi_slave_mem;

  logic        aclk = 1'b0;
  logic        areset = 1'b0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;

  int checks = 0;
  int passes = 0;

  // transaction buffers shared by the driver tasks and the tests
  logic [31:0] wbuf [16];
  logic [31:0] rbuf_data [16];
  logic [1:0]  rbuf_resp [16];
  logic        rbuf_last [16];
  int          rd_beats;
  int          rd_cycles;
  logic        rd_first_ok;
  logic        rd_stable_ok;
  logic [1:0]  wr_resp;
  logic        wr_b_first;
  logic        wr_hold_ok;

  axi_slave_mem #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(64)) dut (
    .aclk    (aclk),
    .areset  (areset),
    .awaddr  (awaddr),
    .awlen   (awlen),
    .awsize  (awsize),
    .awburst (awburst),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wlast   (wlast),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .araddr  (araddr),
    .arlen   (arlen),
    .arsize  (arsize),
    .arburst (arburst),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready)
  );

  always #5 aclk = ~aclk;

  // last_mode: 0 = wlast on final beat, 1 = also on beat 0, 2 = never.
  // hold: cycles bready stays low once bvalid is seen.
  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [3:0] strb, input int last_mode,
                           input int hold);
    int n;
    @(negedge aclk);
    awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) begin checks++; $display("FAIL aw_timeout awready=%b required=1", awready); end
    @(negedge aclk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata  = wbuf[i];
      wstrb  = strb;
      wlast  = (last_mode == 2) ? 1'b0 :
               (last_mode == 1) ? (i == 0 || i == int'(len)) : (i == int'(len));
      wvalid = 1'b1;
      n = 0;
      while (!wready && n < 50) begin @(negedge aclk); n++; end
      if (n >= 50) begin checks++; $display("FAIL w_timeout wready=%b required=1", wready); end
      @(negedge aclk);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    wr_b_first = bvalid;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) begin checks++; $display("FAIL b_timeout bvalid=%b required=1", bvalid); end
    wr_hold_ok = 1'b1;
    for (int k = 0; k < hold; k++) begin
      if (!bvalid || awready) wr_hold_ok = 1'b0;
      @(negedge aclk);
    end
    if (!bvalid || awready) wr_hold_ok = 1'b0;
    wr_resp = bresp;
    bready  = 1'b1;
    @(negedge aclk);
    bready  = 1'b0;
    $display("write addr=%h len=%0d size=%0d burst=%0d bresp=%b", addr, len, size, burst, wr_resp);
  endtask

  // toggle=1 drives rready 0,1,0,1... while the burst is returned.
  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input bit toggle);
    int          n;
    bit          done;
    bit          held;
    logic [31:0] held_data;
    logic        held_last;
    @(negedge aclk);
    araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge aclk); n++; end
    if (n >= 50) begin checks++; $display("FAIL ar_timeout arready=%b required=1", arready); end
    @(negedge aclk);
    arvalid = 1'b0;
    rd_first_ok  = rvalid;
    rd_beats     = 0;
    rd_stable_ok = 1'b1;
    rd_cycles    = 0;
    done = 0;
    held = 0;
    held_data = '0;
    held_last = 1'b0;
    while (!done && rd_cycles < 200) begin
      rready = toggle ? rd_cycles[0] : 1'b1;
      if (held && (!rvalid || rdata !== held_data || rlast !== held_last)) rd_stable_ok = 1'b0;
      held = 0;
      if (rvalid) begin
        if (rready) begin
          if (rd_beats < 16) begin
            rbuf_data[rd_beats] = rdata;
            rbuf_resp[rd_beats] = rresp;
            rbuf_last[rd_beats] = rlast;
          end
          rd_beats++;
          if (rlast) done = 1;
        end else begin
          held = 1;
          held_data = rdata;
          held_last = rlast;
        end
      end
      @(negedge aclk);
      rd_cycles++;
    end
    rready = 1'b0;
    if (!done) begin checks++; $display("FAIL r_timeout beats=%0d required=%0d", rd_beats, int'(len) + 1); end
    $display("read  addr=%h len=%0d size=%0d burst=%0d beats=%0d first=%h", addr, len, size, burst, rd_beats, rbuf_data[0]);
  endtask

  task automatic test_reset;
    checks++; if (awready !== 1'b1) $display("FAIL reset_awready got=%b exp=1", awready); else passes++;
    checks++; if (arready !== 1'b1) $display("FAIL reset_arready got=%b exp=1", arready); else passes++;
    checks++; if (wready !== 1'b0) $display("FAIL reset_wready got=%b exp=0", wready); else passes++;
    checks++; if (bvalid !== 1'b0) $display("FAIL reset_bvalid got=%b exp=0", bvalid); else passes++;
    checks++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid got=%b exp=0", rvalid); else passes++;
    checks++; if (rlast !== 1'b0) $display("FAIL reset_rlast got=%b exp=0", rlast); else passes++;
    checks++; if (bresp !== 2'b00) $display("FAIL reset_bresp got=%b exp=00", bresp); else passes++;
    checks++; if (rresp !== 2'b00) $display("FAIL reset_rresp got=%b exp=00", rresp); else passes++;
    checks++; if (rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", rdata); else passes++;
  endtask

  task automatic test_single;
    wbuf[0] = 32'hDEADBEEF;
    axi_write(32'h10, 8'd0, 3'd2, 2'b01, 4'hF, 0, 0);
    checks++; if (wr_b_first !== 1'b1) $display("FAIL single_b_latency bvalid=%b exp=1", wr_b_first); else passes++;
    checks++; if (wr_resp !== 2'b00) $display("FAIL single_bresp got=%b exp=00", wr_resp); else passes++;
    axi_read(32'h10, 8'd0, 3'd2, 2'b01, 0);
    checks++; if (rd_first_ok !== 1'b1) $display("FAIL single_r_latency rvalid=%b exp=1", rd_first_ok); else passes++;
    checks++; if (rd_beats !== 1) $display("FAIL single_beats got=%0d exp=1", rd_beats); else passes++;
    checks++; if (rbuf_data[0] !== 32'hDEADBEEF) $display("FAIL single_rdata got=%h exp=deadbeef", rbuf_data[0]); else passes++;
    checks++; if (rbuf_last[0] !== 1'b1) $display("FAIL single_rlast got=%b exp=1", rbuf_last[0]); else passes++;
    checks++; if (rbuf_resp[0] !== 2'b00) $display("FAIL single_rresp got=%b exp=00", rbuf_resp[0]); else passes++;
  endtask

  task automatic test_incr_burst;
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    axi_write(32'h20, 8'd3, 3'd2, 2'b01, 4'hF, 0, 0);
    checks++; if (wr_resp !== 2'b00) $display("FAIL incr_bresp got=%b exp=00", wr_resp); else passes++;
    axi_read(32'h20, 8'd3, 3'd2, 2'b01, 0);
    checks++; if (rd_beats !== 4) $display("FAIL incr_beats got=%0d exp=4", rd_beats); else passes++;
    checks++; if (rd_cycles !== 4) $display("FAIL incr_no_bubble cycles=%0d exp=4", rd_cycles); else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rbuf_data[i] !== 32'(i + 1)) $display("FAIL incr_rdata beat=%0d got=%h exp=%h", i, rbuf_data[i], 32'(i + 1)); else passes++;
      checks++; if (rbuf_last[i] !== (i == 3)) $display("FAIL incr_rlast beat=%0d got=%b exp=%b", i, rbuf_last[i], (i == 3)); else passes++;
    end
  endtask

  task automatic test_backpressure;
    axi_read(32'h20, 8'd3, 3'd2, 2'b01, 1);
    checks++; if (rd_beats !== 4) $display("FAIL bp_beats got=%0d exp=4", rd_beats); else passes++;
    checks++; if (rd_stable_ok !== 1'b1) $display("FAIL bp_r_stable got=%b exp=1", rd_stable_ok); else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rbuf_data[i] !== 32'(i + 1)) $display("FAIL bp_rdata beat=%0d got=%h exp=%h", i, rbuf_data[i], 32'(i + 1)); else passes++;
    end
    checks++; if (rbuf_last[3] !== 1'b1) $display("FAIL bp_rlast got=%b exp=1", rbuf_last[3]); else passes++;
    wbuf[0] = 32'h0BADF00D;
    axi_write(32'h50, 8'd0, 3'd2, 2'b01, 4'hF, 0, 5);
    checks++; if (wr_hold_ok !== 1'b1) $display("FAIL bp_b_hold got=%b exp=1", wr_hold_ok); else passes++;
    checks++; if (wr_resp !== 2'b00) $display("FAIL bp_bresp got=%b exp=00", wr_resp); else passes++;
  endtask

  task automatic test_errors;
    // word 0 gets a marker so an aliased out-of-range write would show up
    wbuf[0] = 32'h5A5A5A5A;
    axi_write(32'h0, 8'd0, 3'd2, 2'b01, 4'hF, 0, 0);
    wbuf[0] = 32'h12345678;
    axi_write(32'h100, 8'd0, 3'd2, 2'b01, 4'hF, 0, 0);
    checks++; if (wr_resp !== 2'b10) $display("FAIL oor_bresp got=%b exp=10", wr_resp); else passes++;
    axi_read(32'h0, 8'd0, 3'd2, 2'b01, 0);
    checks++; if (rbuf_data[0] !== 32'h5A5A5A5A) $display("FAIL oor_mem_unchanged got=%h exp=5a5a5a5a", rbuf_data[0]); else passes++;
    axi_read(32'h100, 8'd0, 3'd2, 2'b01, 0);
    checks++; if (rbuf_resp[0] !== 2'b10) $display("FAIL oor_rresp got=%b exp=10", rbuf_resp[0]); else passes++;
    checks++; if (rbuf_data[0] !== 32'h0) $display("FAIL oor_rdata got=%h exp=0", rbuf_data[0]); else passes++;
    wbuf[0] = 32'h1; wbuf[1] = 32'h2;
    axi_write(32'h60, 8'd1, 3'd2, 2'b01, 4'hF, 1, 0);
    checks++; if (wr_resp !== 2'b10) $display("FAIL early_wlast_bresp got=%b exp=10", wr_resp); else passes++;
    axi_write(32'h60, 8'd1, 3'd2, 2'b01, 4'hF, 2, 0);
    checks++; if (wr_resp !== 2'b10) $display("FAIL missing_wlast_bresp got=%b exp=10", wr_resp); else passes++;
    axi_read(32'h0, 8'd1, 3'd3, 2'b01, 0);
    checks++; if (rd_beats !== 2) $display("FAIL size_beats got=%0d exp=2", rd_beats); else passes++;
    for (int i = 0; i < 2; i++) begin
      checks++; if (rbuf_resp[i] !== 2'b10) $display("FAIL size_rresp beat=%0d got=%b exp=10", i, rbuf_resp[i]); else passes++;
      checks++; if (rbuf_data[i] !== 32'h0) $display("FAIL size_rdata beat=%0d got=%h exp=0", i, rbuf_data[i]); else passes++;
    end
  endtask

  task automatic test_partial_strobe;
    wbuf[0] = 32'hFFFFFFFF;
    axi_write(32'h30, 8'd0, 3'd2, 2'b01, 4'hF, 0, 0);
    wbuf[0] = 32'hAABBCCDD;
    axi_write(32'h30, 8'd0, 3'd2, 2'b01, 4'h3, 0, 0);
    axi_read(32'h30, 8'd0, 3'd2, 2'b01, 0);
    checks++; if (rbuf_data[0] !== 32'hFFFFCCDD) $display("FAIL strobe_rdata got=%h exp=ffffccdd", rbuf_data[0]); else passes++;
  endtask

  task automatic test_reset_mid_read;
    bit quiet;
    @(negedge aclk);
    araddr = 32'h20; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    rready = 1'b0;
    @(negedge aclk);
    arvalid = 1'b0;
    @(negedge aclk);
    checks++; if (rvalid !== 1'b1) $display("FAIL midrst_pre_rvalid got=%b exp=1", rvalid); else passes++;
    areset = 1'b0;
    @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    checks++; if (rvalid !== 1'b0) $display("FAIL midrst_rvalid got=%b exp=0", rvalid); else passes++;
    checks++; if (arready !== 1'b1) $display("FAIL midrst_arready got=%b exp=1", arready); else passes++;
    checks++; if (rlast !== 1'b0) $display("FAIL midrst_rlast got=%b exp=0", rlast); else passes++;
    rready = 1'b1;
    quiet = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      if (rvalid !== 1'b0) quiet = 0;
    end
    rready = 1'b0;
    checks++; if (quiet !== 1'b1) $display("FAIL midrst_no_resume got=%b exp=1", quiet); else passes++;
    $display("reset pulsed during read burst at 20");
    axi_read(32'h24, 8'd0, 3'd2, 2'b01, 0);
    checks++; if (rbuf_data[0] !== 32'h2) $display("FAIL midrst_mem_kept got=%h exp=2", rbuf_data[0]); else passes++;
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
    axi_write(32'h10, 8'd3, 3'd2, 2'b01, 4'hF, 0, 0);
    axi_read(32'h18, 8'd3, 3'd2, 2'b10, 0);
    checks++; if (rd_beats !== 4) $display("FAIL wrap_beats got=%0d exp=4", rd_beats); else passes++;
`ifdef AXI_SLAVE_WRAP_EN
    // addresses 18, 1C, 10, 14
    checks++; if (rbuf_data[0] !== 32'hA2) $display("FAIL wrap_beat0 got=%h exp=a2", rbuf_data[0]); else passes++;
    checks++; if (rbuf_data[1] !== 32'hA3) $display("FAIL wrap_beat1 got=%h exp=a3", rbuf_data[1]); else passes++;
    checks++; if (rbuf_data[2] !== 32'hA0) $display("FAIL wrap_beat2 got=%h exp=a0", rbuf_data[2]); else passes++;
    checks++; if (rbuf_data[3] !== 32'hA1) $display("FAIL wrap_beat3 got=%h exp=a1", rbuf_data[3]); else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rbuf_resp[i] !== 2'b00) $display("FAIL wrap_rresp beat=%0d got=%b exp=00", i, rbuf_resp[i]); else passes++;
    end
`else
    for (int i = 0; i < 4; i++) begin
      checks++; if (rbuf_resp[i] !== 2'b10) $display("FAIL wrap_rresp beat=%0d got=%b exp=10", i, rbuf_resp[i]); else passes++;
      checks++; if (rbuf_data[i] !== 32'h0) $display("FAIL wrap_rdata beat=%0d got=%h exp=0", i, rbuf_data[i]); else passes++;
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      wbuf[i] = '0; rbuf_data[i] = '0; rbuf_resp[i] = '0; rbuf_last[i] = 1'b0;
    end
    rd_beats = 0; rd_cycles = 0; rd_first_ok = 1'b0; rd_stable_ok = 1'b0;
    wr_resp = '0; wr_b_first = 1'b0; wr_hold_ok = 1'b0;
    repeat (3) @(negedge aclk);
    test_reset;
    areset = 1'b1;
    @(negedge aclk);
    test_reset;
    test_single;
    test_incr_burst;
    test_backpressure;
    test_errors;
    test_partial_strobe;
    test_reset_mid_read;
    test_wrap;
    repeat (2) @(negedge aclk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
